// File: rtl/ctrl_pkg.sv
// Shared encodings for the ARM-subset control unit.
// Contents: instruction field encodings (op, cmd, cond), datapath select
// codes (ImmSrc, ALUControl), the architectural flag layout and the FSM
// state type.
package ctrl_pkg;

  // op field, Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // cmd field, Instr[24:21]; only these five are implemented
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // cond field, Instr[31:28]; 4'b1111 is undefined
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  typedef enum logic [1:0] {
    IMM_8  = 2'b00,   // imm8 zero-extended
    IMM_12 = 2'b01,   // imm12 zero-extended
    IMM_24 = 2'b10    // imm24 sign-extended, times 4
  } imm_src_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath connection.
// Datapath side (master) supplies the fetched instruction and the
// combinational ALU flags; the control unit (slave) returns every datapath
// control input.
interface control_unit_if;
  logic [31:0] Instr;
  logic        Z;
  logic        N;
  logic        C;
  logic        V;
  logic        PCSrc;
  logic        PCWrite;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        MemWrite;
  logic        MemtoReg;

  modport master (
    output Instr, Z, N, C, V,
    input  PCSrc, PCWrite, RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
           MemWrite, MemtoReg
  );

  modport slave (
    input  Instr, Z, N, C, V,
    output PCSrc, PCWrite, RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
           MemWrite, MemtoReg
  );
endinterface

// File: rtl/cond_check.sv
// Condition-field evaluation against the registered NZCV flags.
// Ports:
//   cond    in  4  Instr[31:28]
//   flags   in     registered N,Z,C,V
//   cond_ex out 1  instruction may commit its side effects
//   undef   out 1  cond is the reserved 4'b1111 encoding
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       cond_ex,
  output logic       undef
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    cond_ex = 1'b0;
    undef   = 1'b0;
    case (cond)
      COND_EQ: cond_ex = flags.z;
      COND_NE: cond_ex = !flags.z;
      COND_CS: cond_ex = flags.c;
      COND_CC: cond_ex = !flags.c;
      COND_MI: cond_ex = flags.n;
      COND_PL: cond_ex = !flags.n;
      COND_VS: cond_ex = flags.v;
      COND_VC: cond_ex = !flags.v;
      COND_HI: cond_ex = flags.c && !flags.z;
      COND_LS: cond_ex = !flags.c || flags.z;
      COND_GE: cond_ex = (flags.n == flags.v);
      COND_LT: cond_ex = (flags.n != flags.v);
      COND_GT: cond_ex = !flags.z && (flags.n == flags.v);
      COND_LE: cond_ex = flags.z || (flags.n != flags.v);
      COND_AL: cond_ex = 1'b1;
      default: undef   = 1'b1;  // 4'b1111
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Single-cycle control unit for the ARM-subset processor.
// Decodes the fetched instruction into datapath controls, holds the NZCV
// flag register, evaluates the condition field, halts on undefined
// encodings and counts retired instructions.
// Ports:
//   clock    in        rising-edge clock
//   reset_n  in        asynchronous active-low reset
//   bus      slave     Instr, ALU flags in; datapath controls out
//   halted   out 1     FSM is in HALT
//   retired  out CNT_W instructions executed with the condition passed
module control_unit
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  control_unit_if.slave    bus,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;   // S for data processing, L for memory
  logic [3:0] rd;

  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign i_bit = bus.Instr[25];
  assign cmd   = bus.Instr[24:21];
  assign s_bit = bus.Instr[20];
  assign rd    = bus.Instr[15:12];

  // Rn and the immediate/Rm bits are consumed by the datapath only.
  logic unused_instr;
  assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:0]};

  flags_t flags_q;
  state_e state_q, state_d;

  logic cond_ex, cond_undef;

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex),
    .undef   (cond_undef)
  );

  // Main decoder: datapath selects plus the unqualified write intents.
  logic [1:0] reg_src;
  imm_src_e   imm_src;
  logic       alu_src;
  logic       mem_to_reg;
  logic       reg_write_d;
  logic       mem_write_d;
  logic       branch;
  logic       dp_op;
  logic       op_undef;

  always_comb begin
    reg_src     = 2'b00;
    imm_src     = IMM_8;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write_d = 1'b0;
    mem_write_d = 1'b0;
    branch      = 1'b0;
    dp_op       = 1'b0;
    op_undef    = 1'b0;
    case (op)
      OP_DP: begin
        dp_op       = 1'b1;
        alu_src     = i_bit;
        reg_write_d = 1'b1;
      end
      OP_MEM: begin
        imm_src = IMM_12;
        alu_src = 1'b1;
        if (s_bit) begin          // LDR
          mem_to_reg  = 1'b1;
          reg_write_d = 1'b1;
        end else begin            // STR: RA2 reads the store data from Rd
          reg_src     = 2'b10;
          mem_write_d = 1'b1;
        end
      end
      OP_BR: begin
        reg_src = 2'b01;          // RA1 = R15 so the target is PC-relative
        imm_src = IMM_24;
        alu_src = 1'b1;
        branch  = 1'b1;
      end
      default: op_undef = 1'b1;
    endcase
  end

  // ALU decoder: operation, flag-update class, and CMP's suppressed write.
  alu_ctrl_e alu_ctrl;
  logic      arith;      // add/sub/cmp update all four flags
  logic      no_wb;      // CMP computes but never writes Rd
  logic      cmd_undef;

  always_comb begin
    alu_ctrl  = ALU_ADD;
    arith     = 1'b0;
    no_wb     = 1'b0;
    cmd_undef = 1'b0;
    if (dp_op) begin
      case (cmd)
        CMD_ADD: begin alu_ctrl = ALU_ADD; arith = 1'b1; end
        CMD_SUB: begin alu_ctrl = ALU_SUB; arith = 1'b1; end
        CMD_AND: alu_ctrl = ALU_AND;
        CMD_ORR: alu_ctrl = ALU_ORR;
        CMD_CMP: begin
          alu_ctrl  = ALU_SUB;
          arith     = 1'b1;
          no_wb     = 1'b1;
          cmd_undef = !s_bit;     // CMP without S has no meaning here
        end
        default: cmd_undef = 1'b1;
      endcase
    end
  end

  // Commit qualification. reset_n is folded in so the write enables drop
  // the moment reset asserts, not at the next edge.
  logic undef_all;
  logic run;
  logic exec;
  logic reg_write;
  logic flag_we;

  assign undef_all = op_undef | cmd_undef | cond_undef;
  assign run       = (state_q == ST_RUN) && reset_n;
  assign exec      = run && !undef_all && cond_ex;
  assign reg_write = exec && reg_write_d && !no_wb;
  assign flag_we   = exec && dp_op && s_bit;

  assign bus.PCWrite    = run;
  assign bus.PCSrc      = exec && (branch || (reg_write_d && !no_wb && rd == 4'd15));
  assign bus.RegWrite   = reg_write;
  assign bus.MemWrite   = exec && mem_write_d;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.RegSrc     = reg_src;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUSrc     = alu_src;
  assign bus.ALUControl = alu_ctrl;
  assign halted         = (state_q == ST_HALT);

  // HALT is absorbing; only reset returns to RUN.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && undef_all) state_d = ST_HALT;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      flags_q <= '0;
      retired <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      if (flag_we) begin
        flags_q.n <= bus.N;
        flags_q.z <= bus.Z;
        if (arith) begin         // logical ops leave C and V untouched
          flags_q.c <= bus.C;
          flags_q.v <= bus.V;
        end
      end
      if (exec) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. Each scenario drives instructions
// at the falling edge, queues the expected controls and retire count, and
// compares them mid-cycle, before the rising edge that executes them.
module tb_control_unit;

  logic        clock;
  logic        reset_n;
  logic        halted;
  logic [31:0] retired;

  control_unit_if bus ();

  control_unit #(.CNT_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .halted  (halted),
    .retired (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Control vector layout:
  // {PCSrc, PCWrite, RegSrc[1:0], RegWrite, ImmSrc[1:0], ALUSrc,
  //  ALUControl[1:0], MemWrite, MemtoReg, halted}
  function automatic logic [12:0] mk(logic pcsrc, logic pcw, logic [1:0] rs,
                                     logic rw, logic [1:0] imm, logic as,
                                     logic [1:0] alu, logic mw, logic mtr,
                                     logic h);
    return {pcsrc, pcw, rs, rw, imm, as, alu, mw, mtr, h};
  endfunction

  function automatic logic [12:0] obs();
    return {bus.PCSrc, bus.PCWrite, bus.RegSrc, bus.RegWrite, bus.ImmSrc,
            bus.ALUSrc, bus.ALUControl, bus.MemWrite, bus.MemtoReg, halted};
  endfunction

  localparam logic [12:0] M_ALL = 13'h1FFF;
  // PCSrc, PCWrite, RegWrite, MemWrite, halted
  localparam logic [12:0] M_EN  = 13'b1_1_00_1_00_0_00_1_0_1;

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  alu;     // ALU flag inputs {N,Z,C,V}
    logic [12:0] exp;
    logic [12:0] mask;
    logic        ret;     // instruction is expected to retire
  } step_t;

  typedef struct packed {
    logic [12:0] exp;
    logic [12:0] mask;
    logic [31:0] ret;
  } sb_t;

  sb_t         sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_retired = '0;

  function automatic step_t st(logic [31:0] instr, logic [3:0] alu,
                               logic [12:0] exp, logic ret);
    return '{instr: instr, alu: alu, exp: exp, mask: M_ALL, ret: ret};
  endfunction

  function automatic step_t stm(logic [31:0] instr, logic [3:0] alu,
                                logic [12:0] exp, logic [12:0] mask, logic ret);
    return '{instr: instr, alu: alu, exp: exp, mask: mask, ret: ret};
  endfunction

  // Stimulus: apply one instruction at the falling edge and queue what the
  // DUT must show during this cycle.
  task automatic drive(input step_t s);
    @(negedge clock);
    bus.Instr = s.instr;
    {bus.N, bus.Z, bus.C, bus.V} = s.alu;
    sb.push_back('{exp: s.exp, mask: s.mask, ret: exp_retired});
    if (s.ret) exp_retired = exp_retired + 32'd1;
  endtask

  // Common decodes
  localparam logic [31:0] ADDS = 32'hE0921003;
  localparam logic [31:0] STR  = 32'hE5821004;
  localparam logic [31:0] BEQ  = 32'h0A000002;
  localparam logic [31:0] BNE  = 32'h1A000002;

  task automatic test_reset();
    step_t s[$];
    sb_t   e;
    reset_n = 1'b0;
    s.push_back(st(ADDS, 4'b0100, mk(0,0,2'b00,0,2'b00,0,2'b00,0,0,0), 0));
    s.push_back(st(STR,  4'b0000, mk(0,0,2'b10,0,2'b01,1,2'b00,0,0,0), 0));
    foreach (s[i]) begin
      drive(s[i]);
      #2;
      e = sb.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.exp & e.mask)) begin
        n_errors++;
        $display("FAIL reset[%0d] ctrl got=%b exp=%b", i, obs(), e.exp);
      end
      n_checks++;
      if (retired !== e.ret) begin
        n_errors++;
        $display("FAIL reset[%0d] retired got=%0d exp=%0d", i, retired, e.ret);
      end
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_dp();
    step_t s[$];
    sb_t   e;
    s.push_back(st(ADDS,         4'b0100, mk(0,1,2'b00,1,2'b00,0,2'b00,0,0,0), 1));
    s.push_back(st(32'hE0421003, 4'b1111, mk(0,1,2'b00,1,2'b00,0,2'b01,0,0,0), 1));
    s.push_back(st(32'hE0021003, 4'b1111, mk(0,1,2'b00,1,2'b00,0,2'b10,0,0,0), 1));
    s.push_back(st(32'hE1821003, 4'b1111, mk(0,1,2'b00,1,2'b00,0,2'b11,0,0,0), 1));
    s.push_back(st(32'hE2821005, 4'b0000, mk(0,1,2'b00,1,2'b00,1,2'b00,0,0,0), 1));
    s.push_back(st(32'hE082F003, 4'b0000, mk(1,1,2'b00,1,2'b00,0,2'b00,0,0,0), 1));
    foreach (s[i]) begin
      drive(s[i]);
      #2;
      e = sb.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.exp & e.mask)) begin
        n_errors++;
        $display("FAIL dp[%0d] ctrl got=%b exp=%b", i, obs(), e.exp);
      end
      n_checks++;
      if (retired !== e.ret) begin
        n_errors++;
        $display("FAIL dp[%0d] retired got=%0d exp=%0d", i, retired, e.ret);
      end
    end
  endtask

  // Flags left by test_dp: N0 Z1 C0 V0
  task automatic test_branch_flags();
    step_t s[$];
    sb_t   e;
    logic [12:0] b_take, b_skip;
    b_take = mk(1,1,2'b01,0,2'b10,1,2'b00,0,0,0);
    b_skip = mk(0,1,2'b01,0,2'b10,1,2'b00,0,0,0);
    s.push_back(st(BEQ,          4'b0000, b_take, 1));
    s.push_back(st(ADDS,         4'b0010, mk(0,1,2'b00,1,2'b00,0,2'b00,0,0,0), 1));
    s.push_back(st(BEQ,          4'b0000, b_skip, 0));
    s.push_back(st(BNE,          4'b0000, b_take, 1));
    s.push_back(st(32'hE0121003, 4'b0000, mk(0,1,2'b00,1,2'b00,0,2'b10,0,0,0), 1));
    s.push_back(st(32'h2A000002, 4'b0000, b_take, 1));   // BCS: C held by ANDS
    s.push_back(st(32'hE0521003, 4'b1001, mk(0,1,2'b00,1,2'b00,0,2'b01,0,0,0), 1));
    s.push_back(st(32'h3A000002, 4'b0000, b_take, 1));   // BCC
    s.push_back(st(32'hAA000002, 4'b0000, b_take, 1));   // BGE
    s.push_back(st(32'h4A000002, 4'b0000, b_take, 1));   // BMI
    s.push_back(st(32'h7A000002, 4'b0000, b_skip, 0));   // BVC
    foreach (s[i]) begin
      drive(s[i]);
      #2;
      e = sb.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.exp & e.mask)) begin
        n_errors++;
        $display("FAIL branch[%0d] ctrl got=%b exp=%b", i, obs(), e.exp);
      end
      n_checks++;
      if (retired !== e.ret) begin
        n_errors++;
        $display("FAIL branch[%0d] retired got=%0d exp=%0d", i, retired, e.ret);
      end
    end
  endtask

  task automatic test_mem();
    step_t s[$];
    sb_t   e;
    s.push_back(st(STR,          4'b0000, mk(0,1,2'b10,0,2'b01,1,2'b00,1,0,0), 1));
    s.push_back(st(32'hE5921004, 4'b0000, mk(0,1,2'b00,1,2'b01,1,2'b00,0,1,0), 1));
    foreach (s[i]) begin
      drive(s[i]);
      #2;
      e = sb.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.exp & e.mask)) begin
        n_errors++;
        $display("FAIL mem[%0d] ctrl got=%b exp=%b", i, obs(), e.exp);
      end
      n_checks++;
      if (retired !== e.ret) begin
        n_errors++;
        $display("FAIL mem[%0d] retired got=%0d exp=%0d", i, retired, e.ret);
      end
    end
  endtask

  task automatic test_cmp_cond();
    step_t s[$];
    sb_t   e;
    logic [12:0] cmp, add_y, add_n;
    cmp   = mk(0,1,2'b00,0,2'b00,0,2'b01,0,0,0);
    add_y = mk(0,1,2'b00,1,2'b00,0,2'b00,0,0,0);
    add_n = mk(0,1,2'b00,0,2'b00,0,2'b00,0,0,0);
    s.push_back(st(32'hE1510002, 4'b1000, cmp,   1));   // flags -> N
    s.push_back(st(32'hB0811002, 4'b0000, add_y, 1));   // ADDLT
    s.push_back(st(32'hA0811002, 4'b0000, add_n, 0));   // ADDGE
    s.push_back(st(32'hE1510002, 4'b0100, cmp,   1));   // flags -> Z
    s.push_back(st(32'hC0811002, 4'b0000, add_n, 0));   // ADDGT
    s.push_back(st(32'hD0811002, 4'b0000, add_y, 1));   // ADDLE
    s.push_back(st(32'h90811002, 4'b0000, add_y, 1));   // ADDLS
    s.push_back(st(32'h80811002, 4'b0000, add_n, 0));   // ADDHI
    foreach (s[i]) begin
      drive(s[i]);
      #2;
      e = sb.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.exp & e.mask)) begin
        n_errors++;
        $display("FAIL cmp[%0d] ctrl got=%b exp=%b", i, obs(), e.exp);
      end
      n_checks++;
      if (retired !== e.ret) begin
        n_errors++;
        $display("FAIL cmp[%0d] retired got=%0d exp=%0d", i, retired, e.ret);
      end
    end
  endtask

  task automatic test_halt();
    logic [31:0] und[4];
    logic [12:0] und_exp[4];
    logic [12:0] und_mask[4];
    step_t s[$];
    sb_t   e;
    und[0] = 32'hF0000000;  und_mask[0] = M_ALL;   // cond NV
    und[1] = 32'hE1410002;  und_mask[1] = M_ALL;   // CMP without S
    und[2] = 32'hEC000000;  und_mask[2] = M_EN;    // op 11
    und[3] = 32'hE0221003;  und_mask[3] = M_EN;    // unimplemented cmd
    und_exp[0] = mk(0,1,2'b00,0,2'b00,0,2'b10,0,0,0);
    und_exp[1] = mk(0,1,2'b00,0,2'b00,0,2'b01,0,0,0);
    und_exp[2] = mk(0,1,2'b00,0,2'b00,0,2'b00,0,0,0);
    und_exp[3] = und_exp[2];
    for (int k = 0; k < 4; k++) begin
      s.delete();
      s.push_back(stm(und[k], 4'b0100, und_exp[k], und_mask[k], 0));
      s.push_back(st(ADDS, 4'b0100, mk(0,0,2'b00,0,2'b00,0,2'b00,0,0,1), 0));
      s.push_back(stm(STR, 4'b0000, mk(0,0,2'b00,0,2'b00,0,2'b00,0,0,1), M_EN, 0));
      foreach (s[i]) begin
        drive(s[i]);
        #2;
        e = sb.pop_front();
        n_checks++;
        if ((obs() & e.mask) !== (e.exp & e.mask)) begin
          n_errors++;
          $display("FAIL halt%0d[%0d] ctrl got=%b exp=%b", k, i, obs(), e.exp);
        end
        n_checks++;
        if (retired !== e.ret) begin
          n_errors++;
          $display("FAIL halt%0d[%0d] retired got=%0d exp=%0d", k, i, retired, e.ret);
        end
      end
      #1 reset_n = 1'b0;
      exp_retired = '0;
      #1;
      n_checks++;
      if (halted !== 1'b0 || retired !== 32'd0) begin
        n_errors++;
        $display("FAIL halt%0d exit halted=%b retired=%0d exp 0/0", k, halted, retired);
      end
      @(posedge clock);
      #1 reset_n = 1'b1;
    end
  endtask

  task automatic test_reset_midcycle();
    step_t s[$];
    sb_t   e;
    s.push_back(st(ADDS, 4'b0100, mk(0,1,2'b00,1,2'b00,0,2'b00,0,0,0), 1));
    s.push_back(st(BEQ,  4'b0000, mk(1,1,2'b01,0,2'b10,1,2'b00,0,0,0), 1));
    s.push_back(st(STR,  4'b0000, mk(0,1,2'b10,0,2'b01,1,2'b00,1,0,0), 1));
    foreach (s[i]) begin
      drive(s[i]);
      #2;
      e = sb.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.exp & e.mask)) begin
        n_errors++;
        $display("FAIL midrst[%0d] ctrl got=%b exp=%b", i, obs(), e.exp);
      end
      n_checks++;
      if (retired !== e.ret) begin
        n_errors++;
        $display("FAIL midrst[%0d] retired got=%0d exp=%0d", i, retired, e.ret);
      end
    end
    // Still inside the STR cycle, well before the next rising edge.
    #1 reset_n = 1'b0;
    exp_retired = '0;
    sb.push_back('{exp: mk(0,0,2'b10,0,2'b01,1,2'b00,0,0,0), mask: M_ALL, ret: exp_retired});
    #1;
    e = sb.pop_front();
    n_checks++;
    if ((obs() & e.mask) !== (e.exp & e.mask)) begin
      n_errors++;
      $display("FAIL midrst async ctrl got=%b exp=%b", obs(), e.exp);
    end
    n_checks++;
    if (retired !== e.ret) begin
      n_errors++;
      $display("FAIL midrst async retired got=%0d exp=%0d", retired, e.ret);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    // Flags were cleared: BNE taken, BEQ not; counting restarts at 0.
    s.delete();
    s.push_back(st(BNE, 4'b0000, mk(1,1,2'b01,0,2'b10,1,2'b00,0,0,0), 1));
    s.push_back(st(BEQ, 4'b0000, mk(0,1,2'b01,0,2'b10,1,2'b00,0,0,0), 0));
    foreach (s[i]) begin
      drive(s[i]);
      #2;
      e = sb.pop_front();
      n_checks++;
      if ((obs() & e.mask) !== (e.exp & e.mask)) begin
        n_errors++;
        $display("FAIL postrst[%0d] ctrl got=%b exp=%b", i, obs(), e.exp);
      end
      n_checks++;
      if (retired !== e.ret) begin
        n_errors++;
        $display("FAIL postrst[%0d] retired got=%0d exp=%0d", i, retired, e.ret);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.Instr = '0;
    {bus.N, bus.Z, bus.C, bus.V} = 4'b0000;
    test_reset();
    test_dp();
    test_branch_flags();
    test_mem();
    test_cmp_cond();
    test_halt();
    test_reset_midcycle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

endmodule
